// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver
//   HUB75 LED-panel scan driver with binary-coded-modulation colour depth.
//   For every (row, plane) it requests PANEL_WIDTH pixels from the painter,
//   clocks the returned bits into the panel, latches them and lights the row
//   for BASE_DISPLAY << plane clock periods while the next plane is shifted.
//   Plane is the inner scan loop, row the outer loop.
//
// Ports
//   clk          panel clock
//   reset        synchronous, active-high
//   pix_x        column requested from the painter
//   pix_y        row requested (upper/lower half select is added externally)
//   pix_plane    bit plane requested
//   pix_rgb0/1   painter {r,g,b} bits for upper/lower half, valid
//                PIXEL_LATENCY cycles after the request was presented
//   led_rgb0/1   registered panel data for upper/lower half
//   led_addr     displayed row address
//   led_blank    DDR pair, bit0 = first half-cycle, bit1 = second half-cycle
//   led_latch    DDR pair, same convention
//   led_sclk     DDR pair, same convention (10 = rising edge mid-cycle)
//   frame_start  one-cycle pulse when the scan wraps to row 0, plane 0
//   frame_count  frames completed, wraps at 16 bits
module hub75_bcm_driver #(
    parameter int PANEL_WIDTH   = 64,
    parameter int ADDR_BITS     = 5,
    parameter int COLOR_BITS    = 4,
    parameter int PIXEL_LATENCY = 1,
    parameter int BASE_DISPLAY  = 32,
    localparam int XW = $clog2(PANEL_WIDTH),
    localparam int PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [XW-1:0]        pix_x,
    output logic [ADDR_BITS-1:0] pix_y,
    output logic [PW-1:0]        pix_plane,
    input  logic [2:0]           pix_rgb0,
    input  logic [2:0]           pix_rgb1,
    output logic [2:0]           led_rgb0,
    output logic [2:0]           led_rgb1,
    output logic [ADDR_BITS-1:0] led_addr,
    output logic [1:0]           led_blank,
    output logic [1:0]           led_latch,
    output logic [1:0]           led_sclk,
    output logic                 frame_start,
    output logic [15:0]          frame_count
);

    localparam int TW = $clog2(BASE_DISPLAY) + COLOR_BITS + 1;
    localparam int CW = $clog2(PANEL_WIDTH + PIXEL_LATENCY);

    localparam logic [CW-1:0]        REQ_LAST   = CW'(PANEL_WIDTH - 1);
    localparam logic [CW-1:0]        CAP_LAST   = CW'(PANEL_WIDTH + PIXEL_LATENCY - 2);
    localparam logic [CW:0]          CAP_START  = (CW + 1)'(PIXEL_LATENCY);
    localparam logic [PW-1:0]        PLANE_LAST = PW'(COLOR_BITS - 1);
    localparam logic [ADDR_BITS-1:0] ROW_LAST   = '1;

    typedef enum logic [1:0] {
        S_SHIFT,
        S_WAIT,
        S_LATCH,
        S_UNBLANK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;         // cycles spent in S_SHIFT for this plane
    logic [CW:0]   cnt_p1;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [TW-1:0] plane_time;
    logic          capture;

    // Blank code for a cycle in which the display timer holds t.
    function automatic logic [1:0] blank_code(input logic [TW-1:0] t);
        if (t > TW'(1))
            return 2'b00;
        else if (t == TW'(1))
            return 2'b01;
        else
            return 2'b11;
    endfunction

    always_comb begin
        // The request presented at shift cycle n returns at edge n+PIXEL_LATENCY-1,
        // so captures run from cnt = PIXEL_LATENCY-1 up to CAP_LAST.
        cnt_p1     = {1'b0, cnt} + 1'b1;
        capture    = (state == S_SHIFT) && (cnt_p1 >= CAP_START);
        plane_time = TW'(BASE_DISPLAY) << pix_plane;
        if (state == S_UNBLANK)
            timer_nxt = plane_time;
        else if (timer != '0)
            timer_nxt = timer - 1'b1;
        else
            timer_nxt = timer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_SHIFT;
            cnt         <= '0;
            timer       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_plane   <= '0;
            led_rgb0    <= '0;
            led_rgb1    <= '0;
            led_addr    <= '0;
            led_blank   <= 2'b11;
            led_latch   <= 2'b00;
            led_sclk    <= 2'b00;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            timer       <= timer_nxt;
            frame_start <= 1'b0;
            led_latch   <= 2'b00;
            led_sclk    <= capture ? 2'b10 : 2'b00;
            // Blank follows the timer everywhere except around the latch.
            led_blank   <= blank_code(timer_nxt);
            if (capture) begin
                led_rgb0 <= pix_rgb0;
                led_rgb1 <= pix_rgb1;
            end

            case (state)
                S_SHIFT: begin
                    // pix_x returns to 0 after the last request so the next
                    // plane starts with column 0 already presented.
                    pix_x <= (cnt < REQ_LAST) ? XW'(cnt + 1'b1) : '0;
                    if (cnt == CAP_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (timer == '0) begin
                        state     <= S_LATCH;
                        led_latch <= 2'b11;
                        led_blank <= 2'b11;
                        led_addr  <= pix_y;
                    end
                end

                S_LATCH: begin
                    state     <= S_UNBLANK;
                    led_blank <= 2'b10;
                end

                S_UNBLANK: begin
                    state <= S_SHIFT;
                    if (pix_plane == PLANE_LAST) begin
                        pix_plane <= '0;
                        if (pix_y == ROW_LAST) begin
                            pix_y       <= '0;
                            frame_start <= 1'b1;
                            frame_count <= frame_count + 1'b1;
                        end else begin
                            pix_y <= pix_y + 1'b1;
                        end
                    end else begin
                        pix_plane <= pix_plane + 1'b1;
                    end
                end

                default: state <= S_SHIFT;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver
//   Self-checking bench for hub75_bcm_driver. Three instances: default
//   parameters (reset behaviour), a small panel with PIXEL_LATENCY=1 and the
//   same panel with PIXEL_LATENCY=3. The expected scan is computed from the
//   shift index alone: shift k covers plane k%2 of row (k/2)%2, requests run
//   for 8 cycles, pulses follow PIXEL_LATENCY cycles later, and each plane is
//   lit for 2*(4<<plane) half-cycles.
module tb_hub75_bcm_driver;

    localparam int PW   = 8;
    localparam int AB   = 1;
    localparam int CB   = 2;
    localparam int BD   = 4;
    localparam int ROWS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int sel    = 0;

    logic rst_d = 1'b1;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [2:0] tbl [0:31];

    function automatic int tidx(input int x, input int p, input int y);
        return (y * CB + p) * PW + x;
    endfunction

    function automatic logic [2:0] paint0(input int x, input int p, input int y);
        return {x[0], p[0], y[0]};
    endfunction

    // ---------------- default instance ----------------
    logic [5:0]  d_pix_x;
    logic [4:0]  d_pix_y;
    logic [1:0]  d_pix_plane;
    logic [2:0]  d_rgb0, d_rgb1, d_led_rgb0, d_led_rgb1;
    logic [4:0]  d_led_addr;
    logic [1:0]  d_blank, d_latch, d_sclk;
    logic        d_fs;
    logic [15:0] d_fc;
    assign d_rgb0 = 3'b101;
    assign d_rgb1 = 3'b010;

    hub75_bcm_driver u_def (
        .clk(clk), .reset(rst_d),
        .pix_x(d_pix_x), .pix_y(d_pix_y), .pix_plane(d_pix_plane),
        .pix_rgb0(d_rgb0), .pix_rgb1(d_rgb1),
        .led_rgb0(d_led_rgb0), .led_rgb1(d_led_rgb1), .led_addr(d_led_addr),
        .led_blank(d_blank), .led_latch(d_latch), .led_sclk(d_sclk),
        .frame_start(d_fs), .frame_count(d_fc)
    );

    // ---------------- small panel, latency 1 ----------------
    logic [2:0]  a_pix_x;
    logic [0:0]  a_pix_y, a_pix_plane, a_led_addr;
    logic [2:0]  a_rgb0, a_rgb1, a_led_rgb0, a_led_rgb1;
    logic [1:0]  a_blank, a_latch, a_sclk;
    logic        a_fs;
    logic [15:0] a_fc;
    assign a_rgb0 = paint0(int'(a_pix_x), int'(a_pix_plane), int'(a_pix_y));
    assign a_rgb1 = tbl[tidx(int'(a_pix_x), int'(a_pix_plane), int'(a_pix_y))];

    hub75_bcm_driver #(
        .PANEL_WIDTH(PW), .ADDR_BITS(AB), .COLOR_BITS(CB),
        .PIXEL_LATENCY(1), .BASE_DISPLAY(BD)
    ) u_a (
        .clk(clk), .reset(rst_a),
        .pix_x(a_pix_x), .pix_y(a_pix_y), .pix_plane(a_pix_plane),
        .pix_rgb0(a_rgb0), .pix_rgb1(a_rgb1),
        .led_rgb0(a_led_rgb0), .led_rgb1(a_led_rgb1), .led_addr(a_led_addr),
        .led_blank(a_blank), .led_latch(a_latch), .led_sclk(a_sclk),
        .frame_start(a_fs), .frame_count(a_fc)
    );

    // ---------------- small panel, latency 3 ----------------
    logic [2:0]  b_pix_x;
    logic [0:0]  b_pix_y, b_pix_plane, b_led_addr;
    logic [2:0]  b_rgb0, b_rgb1, b_led_rgb0, b_led_rgb1, b_s1_0, b_s1_1;
    logic [1:0]  b_blank, b_latch, b_sclk;
    logic        b_fs;
    logic [15:0] b_fc;

    // Painter with two register stages: output in cycle n answers cycle n-2.
    always @(posedge clk) begin
        b_s1_0 <= paint0(int'(b_pix_x), int'(b_pix_plane), int'(b_pix_y));
        b_s1_1 <= tbl[tidx(int'(b_pix_x), int'(b_pix_plane), int'(b_pix_y))];
        b_rgb0 <= b_s1_0;
        b_rgb1 <= b_s1_1;
    end

    hub75_bcm_driver #(
        .PANEL_WIDTH(PW), .ADDR_BITS(AB), .COLOR_BITS(CB),
        .PIXEL_LATENCY(3), .BASE_DISPLAY(BD)
    ) u_b (
        .clk(clk), .reset(rst_b),
        .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_plane(b_pix_plane),
        .pix_rgb0(b_rgb0), .pix_rgb1(b_rgb1),
        .led_rgb0(b_led_rgb0), .led_rgb1(b_led_rgb1), .led_addr(b_led_addr),
        .led_blank(b_blank), .led_latch(b_latch), .led_sclk(b_sclk),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    // Views of whichever small instance is under test.
    logic [2:0]  v_pix_x, v_led_rgb0, v_led_rgb1;
    logic [0:0]  v_pix_y, v_pix_plane, v_led_addr;
    logic [1:0]  v_blank, v_latch, v_sclk;
    logic        v_fs;
    logic [15:0] v_fc;
    assign v_pix_x     = (sel != 0) ? b_pix_x     : a_pix_x;
    assign v_pix_y     = (sel != 0) ? b_pix_y     : a_pix_y;
    assign v_pix_plane = (sel != 0) ? b_pix_plane : a_pix_plane;
    assign v_led_rgb0  = (sel != 0) ? b_led_rgb0  : a_led_rgb0;
    assign v_led_rgb1  = (sel != 0) ? b_led_rgb1  : a_led_rgb1;
    assign v_led_addr  = (sel != 0) ? b_led_addr  : a_led_addr;
    assign v_blank     = (sel != 0) ? b_blank     : a_blank;
    assign v_latch     = (sel != 0) ? b_latch     : a_latch;
    assign v_sclk      = (sel != 0) ? b_sclk      : a_sclk;
    assign v_fs        = (sel != 0) ? b_fs        : a_fs;
    assign v_fc        = (sel != 0) ? b_fc        : a_fc;

    // Releases reset of the selected small instance and follows n_latch
    // latches, checking every cycle against the scan model.
    task automatic run_scan(input int inst, input int n_latch, input int lat);
        int cyc, cur, req_start, pulses, lit, last_latch, frames, extra, limit;
        int col, pl, rw, ppl, exp_lit;
        bit fend, done, in_win, exp_fs;
        logic [1:0] exp_sclk;
        cyc = 0; cur = 0; req_start = 0; pulses = 0; lit = 0;
        last_latch = -100; frames = 0; extra = 0; fend = 0; done = 0;
        limit = n_latch * 100 + 100;
        sel = inst;
        @(negedge clk);
        if (inst != 0) rst_b = 1'b0; else rst_a = 1'b0;
        while (!done && cyc < limit) begin
            pl = cur % CB;
            rw = (cur / CB) % ROWS;
            if (cyc >= req_start && cyc < req_start + PW) begin
                col = cyc - req_start;
                n_cmp++;
                if ({v_pix_x, v_pix_plane, v_pix_y} !== {3'(col), 1'(pl), 1'(rw)}) begin
                    n_fail++;
                    $display("FAIL pix_request cyc %0d: got x/plane/row %0d/%0d/%0d, want %0d/%0d/%0d",
                             cyc, v_pix_x, v_pix_plane, v_pix_y, col, pl, rw);
                end
            end
            in_win   = (cyc >= req_start + lat) && (cyc < req_start + lat + PW);
            exp_sclk = in_win ? 2'b10 : 2'b00;
            n_cmp++;
            if (v_sclk !== exp_sclk) begin
                n_fail++;
                $display("FAIL sclk cyc %0d: got %b, want %b", cyc, v_sclk, exp_sclk);
            end
            if (in_win) begin
                col = cyc - req_start - lat;
                n_cmp++;
                if ({v_led_rgb0, v_led_rgb1} !== {paint0(col, pl, rw), tbl[tidx(col, pl, rw)]}) begin
                    n_fail++;
                    $display("FAIL led_rgb col %0d plane %0d row %0d: got %b/%b, want %b/%b",
                             col, pl, rw, v_led_rgb0, v_led_rgb1,
                             paint0(col, pl, rw), tbl[tidx(col, pl, rw)]);
                end
            end
            if (v_sclk == 2'b10) pulses++;

            exp_fs = fend && (cyc == last_latch + 2);
            n_cmp++;
            if (v_fs !== exp_fs) begin
                n_fail++;
                $display("FAIL frame_start cyc %0d: got %b, want %b", cyc, v_fs, exp_fs);
            end
            if (exp_fs) begin
                n_cmp++;
                if (v_fc !== 16'(frames)) begin
                    n_fail++;
                    $display("FAIL frame_count: got %0d, want %0d", v_fc, frames);
                end
            end

            if (v_latch == 2'b11) begin
                n_cmp++;
                if ({v_blank, v_led_addr} !== {2'b11, 1'(rw)}) begin
                    n_fail++;
                    $display("FAIL latch_cycle shift %0d: got blank %b addr %0d, want 11 addr %0d",
                             cur, v_blank, v_led_addr, rw);
                end
                n_cmp++;
                if (pulses !== PW) begin
                    n_fail++;
                    $display("FAIL sclk_count shift %0d: got %0d, want %0d", cur, pulses, PW);
                end
                if (cur > 0) begin
                    ppl     = (cur - 1) % CB;
                    exp_lit = 2 * (BD << ppl);
                    n_cmp++;
                    if (lit !== exp_lit) begin
                        n_fail++;
                        $display("FAIL lit_halfcycles plane %0d: got %0d, want %0d", ppl, lit, exp_lit);
                    end
                end
                fend = (pl == CB - 1) && (rw == ROWS - 1);
                if (fend) frames++;
                lit        = 0;
                pulses     = 0;
                last_latch = cyc;
                req_start  = cyc + 2;
                cur++;
                if (cur == n_latch) extra = 3;
            end else begin
                n_cmp++;
                if (v_latch !== 2'b00) begin
                    n_fail++;
                    $display("FAIL latch_idle cyc %0d: got %b, want 00", cyc, v_latch);
                end
            end
            lit += (v_blank[0] ? 0 : 1) + (v_blank[1] ? 0 : 1);

            if (extra > 0) begin
                extra--;
                if (extra == 0) done = 1;
            end
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL scan_timeout: saw %0d latches, want %0d", cur, n_latch);
        end
        n_cmp++;
        if (v_fc !== 16'(n_latch / (CB * ROWS))) begin
            n_fail++;
            $display("FAIL final_frame_count: got %0d, want %0d", v_fc, n_latch / (CB * ROWS));
        end
    endtask

    task automatic test_reset();
        logic [46:0] exp_rst;
        bit seen;
        exp_rst = {6'd0, 5'd0, 2'd0, 3'd0, 3'd0, 5'd0, 2'b11, 2'b00, 2'b00, 1'b0, 16'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({d_pix_x, d_pix_y, d_pix_plane, d_led_rgb0, d_led_rgb1, d_led_addr,
                 d_blank, d_latch, d_sclk, d_fs, d_fc} !== exp_rst) begin
                n_fail++;
                $display("FAIL reset_values cycle %0d: got %h, want %h", i,
                         {d_pix_x, d_pix_y, d_pix_plane, d_led_rgb0, d_led_rgb1, d_led_addr,
                          d_blank, d_latch, d_sclk, d_fs, d_fc}, exp_rst);
            end
        end
        rst_d = 1'b0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (d_latch == 2'b11) seen = 1;
            n_cmp++;
            if (d_blank !== 2'b11) begin
                n_fail++;
                $display("FAIL blank_before_first_latch cycle %0d: got %b, want 11", i, d_blank);
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL first_latch_timeout: got no latch, want one within 300 cycles");
        end else if (d_led_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL first_latch_addr: got %0d, want 0", d_led_addr);
        end
    endtask

    task automatic test_scan_frames();
        run_scan(0, 12, 1);
    endtask

    task automatic test_pixel_latency();
        run_scan(1, 8, 3);
    endtask

    task automatic test_reset_midshift();
        int skip, seen, guard;
        sel   = 0;
        skip  = int'($urandom_range(0, 5));
        seen  = 0;
        guard = 0;
        while (seen < skip && guard < 1000) begin
            @(negedge clk);
            if (a_latch == 2'b11) seen++;
            guard++;
        end
        guard = 0;
        while (a_pix_x != 3'd4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (a_pix_x !== 3'd4) begin
            n_fail++;
            $display("FAIL midshift_wait: got pix_x %0d, want 4", a_pix_x);
        end
        rst_a = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_blank, a_sclk, a_pix_x, a_latch} !== {2'b11, 2'b00, 3'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL midshift_reset: got blank %b sclk %b x %0d latch %b, want 11 00 0 00",
                     a_blank, a_sclk, a_pix_x, a_latch);
        end
        run_scan(0, 4, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbl[i] = 3'($urandom);
        test_reset();
        test_scan_frames();
        test_pixel_latency();
        test_reset_midshift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
